quantum_gate_pipe: RTL and testbench

//  Pipelined, parametrised single-qubit gate engine on complex amplitudes (alpha, beta), signed Q(W-F).F.

---
 rtl/quantum_gate_pipe_if.sv | 40 ++++
 rtl/quantum_gate_pipe.sv | 209 ++++++++++++++++++++
 tb/tb_quantum_gate_pipe.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/quantum_gate_pipe_if.sv
// Request/response bundle between the gate controller, quantum_gate_pipe and the state register file.
// Both channels are valid/ready: a beat moves on the rising edge where valid && ready are both 1,
// the sender keeps valid and its data stable until that edge, and ready never looks at the same channel's valid.
interface quantum_gate_pipe_if #(
   parameter int W = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [2:0]   in_gate;
   logic [W-1:0] in_a_re;
   logic [W-1:0] in_a_im;
   logic [W-1:0] in_b_re;
   logic [W-1:0] in_b_im;

   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_a_re;
   logic [W-1:0] out_a_im;
   logic [W-1:0] out_b_re;
   logic [W-1:0] out_b_im;
   logic         out_ovf;
   logic         ovf_sticky;
   logic         clear_ovf;

   // Controller / register-file side.
   modport master (
      output in_valid, in_gate, in_a_re, in_a_im, in_b_re, in_b_im,
      output out_ready, clear_ovf,
      input  in_ready,
      input  out_valid, out_a_re, out_a_im, out_b_re, out_b_im, out_ovf, ovf_sticky
   );

   // Gate engine side.
   modport slave (
      input  in_valid, in_gate, in_a_re, in_a_im, in_b_re, in_b_im,
      input  out_ready, clear_ovf,
      output in_ready,
      output out_valid, out_a_re, out_a_im, out_b_re, out_b_im, out_ovf, ovf_sticky
   );
endinterface

// File: rtl/quantum_gate_pipe.sv
// Two-stage single-qubit gate engine on complex Q(W-F).F amplitudes with saturation and overflow flags.
// Optional QGATE_STATS_EN adds gate_count: results accepted downstream whose gate was not I.
module quantum_gate_pipe #(
   parameter int W = 32,
   parameter int F = 16
) (
   input  logic clk,
   input  logic rst,
`ifdef QGATE_STATS_EN
   output logic [31:0] gate_count,
`endif
   quantum_gate_pipe_if.slave bus
);

   typedef enum logic [2:0] {
      G_I   = 3'b000,
      G_H   = 3'b001,
      G_X   = 3'b010,
      G_Z   = 3'b011,
      G_Y   = 3'b100,
      G_S   = 3'b101,
      G_T   = 3'b110,
      G_SDG = 3'b111
   } gate_t;

   typedef logic signed [W:0]     opnd_t;
   typedef logic signed [2*W+1:0] wide_t;

   // floor(2^F / sqrt2) == floor(sqrt(2^(2F-1))), found with an integer square root.
   function automatic logic [63:0] isqrt(input logic [63:0] n);
      logic [63:0] r;
      logic [63:0] t;
      r = '0;
      for (int b = 31; b >= 0; b--) begin
         t = r | (64'd1 << b);
         if (t * t <= n) r = t;
      end
      return r;
   endfunction

   localparam opnd_t K = opnd_t'(isqrt(64'd1 << (2*F-1)));

   // Clamp to W bits; returns {overflow, value}.
   function automatic logic [W:0] saturate(input wide_t v);
      logic [W+2:0] top;
      top = v[2*W+1:W-1];
      if (top == '0 || top == '1) return {1'b0, v[W-1:0]};
      else if (v[2*W+1])          return {1'b1, 1'b1, {(W-1){1'b0}}};
      else                        return {1'b1, 1'b0, {(W-1){1'b1}}};
   endfunction

   logic en;
   logic take;

   logic         out_valid_q;
   logic [W-1:0] res_q [4];
   logic         ovf_q;
   logic         sticky_q;

   // A stalled output freezes the whole pipe, so one enable serves both stages.
   assign en           = !out_valid_q || bus.out_ready;
   assign take         = bus.in_valid && en;
   assign bus.in_ready = en;

   // ---------------- stage 1: operand formation ----------------
   gate_t gate;
   opnd_t ar, ai, br, bi;
   opnd_t op_n [4];
   logic [3:0] mul_n;

   assign gate = gate_t'(bus.in_gate);
   assign ar   = opnd_t'($signed(bus.in_a_re));
   assign ai   = opnd_t'($signed(bus.in_a_im));
   assign br   = opnd_t'($signed(bus.in_b_re));
   assign bi   = opnd_t'($signed(bus.in_b_im));

   // Slot order is a_re, a_im, b_re, b_im; mul_n marks the slots scaled by K.
   always_comb begin
      op_n[0] = ar;
      op_n[1] = ai;
      op_n[2] = br;
      op_n[3] = bi;
      mul_n   = 4'b0000;
      case (gate)
         G_X: begin
            op_n[0] = br;
            op_n[1] = bi;
            op_n[2] = ar;
            op_n[3] = ai;
         end
         G_Z: begin
            op_n[2] = -br;
            op_n[3] = -bi;
         end
         G_H: begin
            op_n[0] = ar + br;
            op_n[1] = ai + bi;
            op_n[2] = ar - br;
            op_n[3] = ai - bi;
            mul_n   = 4'b1111;
         end
         G_Y: begin
            op_n[0] = bi;
            op_n[1] = -br;
            op_n[2] = -ai;
            op_n[3] = ar;
         end
         G_S: begin
            op_n[2] = -bi;
            op_n[3] = br;
         end
         G_SDG: begin
            op_n[2] = bi;
            op_n[3] = -br;
         end
         G_T: begin
            op_n[2] = br - bi;
            op_n[3] = br + bi;
            mul_n   = 4'b1100;
         end
         default: ;
      endcase
   end

   logic       s1_valid;
   opnd_t      s1_op [4];
   logic [3:0] s1_mul;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_mul   <= 4'b0000;
         for (int k = 0; k < 4; k++) s1_op[k] <= '0;
      end else if (en) begin
         s1_valid <= take;
         if (take) begin
            s1_mul <= mul_n;
            for (int k = 0; k < 4; k++) s1_op[k] <= op_n[k];
         end
      end
   end

   // ---------------- stage 2: scale, shift, saturate ----------------
   wide_t        scaled [4];
   logic [W-1:0] res_n  [4];
   logic [3:0]   ovf_n;

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         if (s1_mul[k]) scaled[k] = (wide_t'(s1_op[k]) * wide_t'(K)) >>> F;
         else           scaled[k] = wide_t'(s1_op[k]);
         {ovf_n[k], res_n[k]} = saturate(scaled[k]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
         for (int k = 0; k < 4; k++) res_q[k] <= '0;
      end else if (en) begin
         out_valid_q <= s1_valid;
         ovf_q       <= s1_valid && (|ovf_n);
         if (s1_valid) begin
            for (int k = 0; k < 4; k++) res_q[k] <= res_n[k];
         end
      end
   end

   // A new overflowing result beats a simultaneous clear.
   always_ff @(posedge clk) begin
      if (rst)                              sticky_q <= 1'b0;
      else if (en && s1_valid && (|ovf_n))  sticky_q <= 1'b1;
      else if (bus.clear_ovf)               sticky_q <= 1'b0;
   end

   assign bus.out_valid  = out_valid_q;
   assign bus.out_a_re   = res_q[0];
   assign bus.out_a_im   = res_q[1];
   assign bus.out_b_re   = res_q[2];
   assign bus.out_b_im   = res_q[3];
   assign bus.out_ovf    = ovf_q;
   assign bus.ovf_sticky = sticky_q;

`ifdef QGATE_STATS_EN
   logic        s1_active;
   logic        out_active_q;
   logic [31:0] count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_active    <= 1'b0;
         out_active_q <= 1'b0;
      end else if (en) begin
         if (take)     s1_active    <= (gate != G_I);
         if (s1_valid) out_active_q <= s1_active;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                                          count_q <= 32'd0;
      else if (bus.clear_ovf)                           count_q <= 32'd0;
      else if (out_valid_q && bus.out_ready && out_active_q) count_q <= count_q + 32'd1;
   end

   assign gate_count = count_q;
`endif

endmodule

// File: tb/tb_quantum_gate_pipe.sv
// Directed bench for quantum_gate_pipe: a driver pushes hand-computed results into a queue and
// an independent monitor pops and compares whenever a result is accepted downstream.
module tb_quantum_gate_pipe;
   localparam int W = 32;
   localparam int F = 16;

   localparam logic [2:0] GI = 3'b000, GH = 3'b001, GX = 3'b010, GZ = 3'b011;
   localparam logic [2:0] GY = 3'b100, GS = 3'b101, GT = 3'b110, GSDG = 3'b111;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   quantum_gate_pipe_if #(.W(W)) bus ();

`ifdef QGATE_STATS_EN
   logic [31:0] gate_count;
`endif

   quantum_gate_pipe #(.W(W), .F(F)) dut (
      .clk(clk),
      .rst(rst),
`ifdef QGATE_STATS_EN
      .gate_count(gate_count),
`endif
      .bus(bus)
   );

   int tests = 0;
   int fails = 0;
   bit lat_check = 1'b1;

   logic [4*W:0] exp_q[$];
   int           cyc_q[$];

   // ---------------- driver tasks ----------------
   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic send(input logic [2:0] g,
                       input logic [W-1:0] ar, input logic [W-1:0] ai,
                       input logic [W-1:0] br, input logic [W-1:0] bi,
                       input logic eo,
                       input logic [W-1:0] ear, input logic [W-1:0] eai,
                       input logic [W-1:0] ebr, input logic [W-1:0] ebi);
      int waits;
      waits = 0;
      bus.in_gate  = g;
      bus.in_a_re  = ar;
      bus.in_a_im  = ai;
      bus.in_b_re  = br;
      bus.in_b_im  = bi;
      bus.in_valid = 1'b1;
      while (bus.in_ready !== 1'b1 && waits < 50) begin
         @(negedge clk);
         waits++;
      end
      if (bus.in_ready !== 1'b1) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: in_ready %b after %0d cycles, required 1", bus.in_ready, waits);
         bus.in_valid = 1'b0;
         return;
      end
      exp_q.push_back({eo, ear, eai, ebr, ebi});
      cyc_q.push_back(cyc);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
         exp_q.delete();
         cyc_q.delete();
      end
   endtask

   task automatic pulse_clear();
      bus.clear_ovf = 1'b1;
      @(negedge clk);
      bus.clear_ovf = 1'b0;
   endtask

   // ---------------- scoreboard monitor ----------------
   logic [4*W:0] held;
   bit           prev_stall = 1'b0;

   always @(negedge clk) begin
      logic [4*W:0] got;
      logic [4*W:0] want;
      int           c0;
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         got = {bus.out_ovf, bus.out_a_re, bus.out_a_im, bus.out_b_re, bus.out_b_im};
         if (prev_stall) begin
            tests++;
            if (got !== held) begin
               fails++;
               $display("FAIL stall_hold: got %h required %h", got, held);
            end
         end
         prev_stall = 1'b0;
         if (bus.out_valid && !bus.out_ready) begin
            tests++;
            if (bus.in_ready !== 1'b0) begin
               fails++;
               $display("FAIL stall_in_ready: got %b required 0", bus.in_ready);
            end
            prev_stall = 1'b1;
            held = got;
         end
         if (bus.out_valid && bus.out_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_result: got %h with nothing expected", got);
            end else begin
               want = exp_q.pop_front();
               c0   = cyc_q.pop_front();
               if (got !== want) begin
                  fails++;
                  $display("FAIL result: got %h required %h", got, want);
               end
               if (lat_check) begin
                  tests++;
                  if (cyc - c0 != 2) begin
                     fails++;
                     $display("FAIL latency: got %0d cycles required 2", cyc - c0);
                  end
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      bus.in_valid  = 1'b0;
      bus.in_gate   = GI;
      bus.in_a_re   = '0;
      bus.in_a_im   = '0;
      bus.in_b_re   = '0;
      bus.in_b_im   = '0;
      bus.out_ready = 1'b1;
      bus.clear_ovf = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      check("rst_out_valid", W'(bus.out_valid), 32'd0);
      check("rst_out_a_re", bus.out_a_re, 32'd0);
      check("rst_out_b_im", bus.out_b_im, 32'd0);
      check("rst_out_ovf", W'(bus.out_ovf), 32'd0);
      check("rst_sticky", W'(bus.ovf_sticky), 32'd0);
      check("rst_in_ready", W'(bus.in_ready), 32'd1);

      // Gate math, full throughput, latency checked.
      send(GH, 32'h10000, 0, 0, 0,            1'b0, 32'hB504, 0, 32'hB504, 0);
      send(GX, 32'h10000, 0, 0, 32'h8000,     1'b0, 0, 32'h8000, 32'h10000, 0);
      send(GZ, 32'h10000, 0, 0, 32'h8000,     1'b0, 32'h10000, 0, 0, 32'hFFFF8000);
      send(GY, 32'h10000, 0, 0, 0,            1'b0, 0, 0, 0, 32'h10000);
      send(GT, 0, 0, 32'h10000, 0,            1'b0, 0, 0, 32'hB504, 32'hB504);
      send(GH, 0, 0, 32'd1, 0,                1'b0, 0, 0, 32'hFFFFFFFF, 0);
      send(GH, 0, 0, 32'h10000, 0,            1'b0, 32'hB504, 0, 32'hFFFF4AFC, 0);
      drain();
      check("sticky_clean", W'(bus.ovf_sticky), 32'd0);

      // Negation of the most negative value.
      send(GZ, 0, 0, 32'h80000000, 0,         1'b1, 0, 0, 32'h7FFFFFFF, 0);
      drain();
      check("sticky_after_z", W'(bus.ovf_sticky), 32'd1);
      pulse_clear();
      check("sticky_cleared", W'(bus.ovf_sticky), 32'd0);

      // H saturating both directions.
      send(GH, 32'h7FFFFFFF, 0, 32'h7FFFFFFF, 0, 1'b1, 32'h7FFFFFFF, 0, 0, 0);
      send(GH, 32'h80000000, 0, 32'h80000000, 0, 1'b1, 32'h80000000, 0, 0, 0);
      drain();
      check("sticky_after_h", W'(bus.ovf_sticky), 32'd1);
      pulse_clear();
      check("sticky_cleared2", W'(bus.ovf_sticky), 32'd0);

      // Clear in the same cycle as a new overflowing result: set wins.
      send(GZ, 0, 0, 32'h80000000, 0,         1'b1, 0, 0, 32'h7FFFFFFF, 0);
      bus.clear_ovf = 1'b1;
      @(negedge clk);
      bus.clear_ovf = 1'b0;
      check("sticky_set_wins", W'(bus.ovf_sticky), 32'd1);
      drain();
      pulse_clear();

      // Backpressure mid-stream.
      lat_check = 1'b0;
      fork
         begin
            send(GI, 32'd1, 32'd2, 32'd3, 32'd4, 1'b0, 32'd1, 32'd2, 32'd3, 32'd4);
            send(GS, 32'h10000, 32'h20000, 32'h30000, 32'h40000,
                 1'b0, 32'h10000, 32'h20000, 32'hFFFC0000, 32'h30000);
            send(GSDG, 32'h10000, 32'h20000, 32'h30000, 32'h40000,
                 1'b0, 32'h10000, 32'h20000, 32'h40000, 32'hFFFD0000);
            send(GX, 32'd5, 32'd6, 32'd7, 32'd8, 1'b0, 32'd7, 32'd8, 32'd5, 32'd6);
            send(GH, 32'h20000, 0, 32'h10000, 0, 1'b0, 32'h21F0C, 0, 32'hB504, 0);
         end
         begin
            repeat (3) @(posedge clk);
            #2 bus.out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #2 bus.out_ready = 1'b1;
         end
      join
      drain();

      // Reset while stalled discards in-flight work.
      @(posedge clk);
      #2 bus.out_ready = 1'b0;
      @(negedge clk);
      send(GX, 32'd9, 0, 32'd10, 0, 1'b0, 32'd10, 0, 32'd9, 0);
      send(GZ, 32'd9, 0, 32'd10, 0, 1'b0, 32'd9, 0, 32'hFFFFFFF6, 0);
      @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst_stall_out_valid", W'(bus.out_valid), 32'd0);
      check("rst_stall_in_ready", W'(bus.in_ready), 32'd1);
      exp_q.delete();
      cyc_q.delete();
      @(posedge clk);
      #2 rst = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("post_reset_idle", W'(bus.out_valid), 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

endmodule
